// File: rtl/pattern_sched_pkg.sv
// Shared definitions for the pattern scan scheduler: FSM encoding,
// the two detected 3-bit patterns and the detector window length.
package pattern_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [2:0] PAT_A   = 3'b111;
    localparam logic [2:0] PAT_B   = 3'b001;
    localparam int         WIN_LEN = 3;

endpackage

// File: rtl/pattern_detect_core.sv
// Serial 3-bit window detector: 2-bit history plus the incoming bit.
// Hit outputs are combinational so the scheduler can count in the same cycle.
module pattern_detect_core
    import pattern_sched_pkg::*;
(
    input  logic clock_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_in_i,
    input  logic win_valid_i,
    output logic hit_a_o,
    output logic hit_b_o
);

    logic [WIN_LEN-2:0] hist_q, hist_d;
    logic [WIN_LEN-1:0] window;

    assign window = {hist_q, bit_in_i};

    always_comb begin
        hist_d = hist_q;
        if (clr_i) begin
            hist_d = '0;
        end else if (en_i) begin
            hist_d = {hist_q[WIN_LEN-3:0], bit_in_i};
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Gating on win_valid keeps cleared history from looking like a leading 00.
    assign hit_a_o = win_valid_i && (window == PAT_A);
    assign hit_b_o = win_valid_i && (window == PAT_B);

endmodule

// File: rtl/pattern_scan_sched.sv
// Two-requester round-robin front end that serializes a captured word MSB-first
// through one shared pattern detector and returns per-job 111/001 counts.
module pattern_scan_sched
    import pattern_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [1:0]       req_i,
    input  logic [WIDTH-1:0] word0_i,
    input  logic [WIDTH-1:0] word1_i,
    output logic [1:0]       grant_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             done_id_o,
    output logic [CNT_W-1:0] cnt111_o,
    output logic [CNT_W-1:0] cnt001_o
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               ptr_q, ptr_d;
    logic [1:0]         grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;
    logic [CNT_W-1:0]   acc_a_q, acc_a_d;
    logic [CNT_W-1:0]   acc_b_q, acc_b_d;
    logic [CNT_W-1:0]   cnt111_q, cnt111_d;
    logic [CNT_W-1:0]   cnt001_q, cnt001_d;

    logic sel;
    logic det_clr, det_en, win_valid;
    logic hit_a, hit_b;

    // Requester 1 wins when it is alone, or on a tie when 0 was served last.
    assign sel       = req_i[1] & (~req_i[0] | ~ptr_q);
    assign win_valid = (state_q == SHIFT) && (idx_q >= IDX_W'(WIN_LEN - 1));

    pattern_detect_core u_core (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .clr_i       (det_clr),
        .en_i        (det_en),
        .bit_in_i    (shreg_q[WIDTH-1]),
        .win_valid_i (win_valid),
        .hit_a_o     (hit_a),
        .hit_b_o     (hit_b)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        grant_d   = 2'b00;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        cnt111_d  = cnt111_q;
        cnt001_d  = cnt001_q;
        det_clr   = 1'b0;
        det_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i != 2'b00) begin
                    grant_d = sel ? 2'b10 : 2'b01;
                    shreg_d = sel ? word1_i : word0_i;
                    ptr_d   = sel;
                    idx_d   = '0;
                    acc_a_d = '0;
                    acc_b_d = '0;
                    det_clr = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                det_en  = 1'b1;
                shreg_d = shreg_q << 1;
                idx_d   = idx_q + IDX_W'(1);
                if (hit_a) acc_a_d = acc_a_q + CNT_W'(1);
                if (hit_b) acc_b_d = acc_b_q + CNT_W'(1);
                if (idx_q == IDX_W'(WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                done_id_d = ptr_q;
                cnt111_d  = acc_a_q;
                cnt001_d  = acc_b_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= 1'b1;
            grant_q   <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
            cnt111_q  <= '0;
            cnt001_q  <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
            cnt111_q  <= cnt111_d;
            cnt001_q  <= cnt001_d;
        end
    end

    assign grant_o   = grant_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign cnt111_o  = cnt111_q;
    assign cnt001_o  = cnt001_q;

endmodule
